// File: rtl/v_issue_ctrl.sv
// In-order issue controller for the vector pipeline. It holds one decoded
// instruction at the handshake, checks it against a per-register pending-write
// scoreboard and the busy state of its target unit, then fires a one-cycle
// start pulse with a registered operand payload. A vconfig waits for every
// unit to drain, then issues on its own dedicated pulse.
module v_issue_ctrl #(
    parameter int NUM_VREG  = 32,
    parameter int NUM_UNITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_unit,
    input  logic                 in_is_vconfig,
    input  logic [4:0]           in_vd,
    input  logic [4:0]           in_vs1,
    input  logic [4:0]           in_vs2,
    input  logic [4:0]           in_vs3,
    input  logic                 in_rd_vs1,
    input  logic                 in_rd_vs2,
    input  logic                 in_rd_vs3,
    input  logic                 in_wr_vd,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] issue,
    output logic                 cfg_issue,
    output logic [4:0]           iss_vd,
    output logic [4:0]           iss_vs1,
    output logic [4:0]           iss_vs2,
    output logic [4:0]           iss_vs3,
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic [NUM_VREG-1:0]  sb_pending,
    output logic                 idle
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CFG} state_t;

    state_t                state_q, state_d;
    logic [NUM_UNITS-1:0]  unit_busy_q, unit_busy_d;
    logic [NUM_UNITS-1:0]  owns_q, owns_d;           // unit holds a scoreboard bit
    logic [4:0]            owner_vd_q [NUM_UNITS];   // register that bit refers to
    logic [4:0]            owner_vd_d [NUM_UNITS];
    logic [NUM_VREG-1:0]   sb_q, sb_d;
    logic [NUM_UNITS-1:0]  issue_q, issue_d;
    logic                  cfg_issue_q, cfg_issue_d;
    logic [4:0]            iss_vd_q, iss_vd_d, iss_vs1_q, iss_vs1_d;
    logic [4:0]            iss_vs2_q, iss_vs2_d, iss_vs3_q, iss_vs3_d;
    logic [4:0]            cap_vd_q, cap_vd_d, cap_vs1_q, cap_vs1_d;
    logic [4:0]            cap_vs2_q, cap_vs2_d, cap_vs3_q, cap_vs3_d;

    logic [NUM_UNITS-1:0]  done_eff, busy_eff, tgt_oh;
    logic [NUM_VREG-1:0]   unit_clr [NUM_UNITS];
    logic [NUM_VREG-1:0]   clr_mask, sb_eff;
    logic                  is_nop, hazard, drained;
    logic                  accept, issue_go, cap_go, cfg_go;

    // Per-unit completion, the register it releases, and target decode.
    // A done pulse only counts for a unit that actually has work in flight.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign done_eff[gi] = unit_done[gi] & unit_busy_q[gi];
            assign busy_eff[gi] = unit_busy_q[gi] & ~unit_done[gi];
            assign unit_clr[gi] = (done_eff[gi] && owns_q[gi])
                                ? (NUM_VREG'(1) << owner_vd_q[gi]) : '0;
            assign tgt_oh[gi]   = ~in_is_vconfig && (in_unit == 3'(gi + 1));
        end
    endgenerate

    // Scoreboard as seen this cycle: bits released by completing units are
    // already gone, so a dependent instruction can go in the done cycle.
    always_comb begin
        clr_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            clr_mask = clr_mask | unit_clr[u];
        end
        sb_eff  = sb_q & ~clr_mask;
        is_nop  = ~|tgt_oh;
        hazard  = (in_rd_vs1 && sb_eff[in_vs1]) || (in_rd_vs2 && sb_eff[in_vs2]) ||
                  (in_rd_vs3 && sb_eff[in_vs3]) || (in_wr_vd  && sb_eff[in_vd]);
        drained = (unit_busy_q == '0);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: vconfig parks in DRAIN until every unit is idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (in_valid && in_is_vconfig) state_d = ST_DRAIN;
            ST_DRAIN: if (drained) state_d = ST_CFG;
            ST_CFG:   state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs: handshake and the events that steer the datapath.
    always_comb begin
        in_ready = (state_q == ST_RUN) && ~in_is_vconfig &&
                   (is_nop || (~hazard && ~|(tgt_oh & busy_eff)));
        accept   = in_valid && in_ready;
        issue_go = accept && ~is_nop;
        cap_go   = (state_q == ST_RUN) && in_valid && in_is_vconfig;
        cfg_go   = (state_q == ST_DRAIN) && drained;
    end

    // Next tracking state and payload; a new issue wins over a same-cycle
    // release of the same unit or register.
    always_comb begin
        unit_busy_d = busy_eff;
        owns_d      = owns_q & ~done_eff;
        owner_vd_d  = owner_vd_q;
        sb_d        = sb_eff;
        if (issue_go && in_wr_vd) begin
            sb_d = sb_eff | (NUM_VREG'(1) << in_vd);
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (issue_go && tgt_oh[u]) begin
                unit_busy_d[u] = 1'b1;
                owns_d[u]      = in_wr_vd;
                owner_vd_d[u]  = in_vd;
            end
        end
        issue_d     = issue_go ? tgt_oh : '0;
        cfg_issue_d = cfg_go;
        iss_vd_d    = iss_vd_q;
        iss_vs1_d   = iss_vs1_q;
        iss_vs2_d   = iss_vs2_q;
        iss_vs3_d   = iss_vs3_q;
        if (issue_go) begin
            iss_vd_d  = in_vd;
            iss_vs1_d = in_vs1;
            iss_vs2_d = in_vs2;
            iss_vs3_d = in_vs3;
        end else if (cfg_go) begin
            iss_vd_d  = cap_vd_q;
            iss_vs1_d = cap_vs1_q;
            iss_vs2_d = cap_vs2_q;
            iss_vs3_d = cap_vs3_q;
        end
        cap_vd_d  = cap_go ? in_vd  : cap_vd_q;
        cap_vs1_d = cap_go ? in_vs1 : cap_vs1_q;
        cap_vs2_d = cap_go ? in_vs2 : cap_vs2_q;
        cap_vs3_d = cap_go ? in_vs3 : cap_vs3_q;
    end

    // Datapath registers; reset forgets all in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_busy_q <= '0;
            owns_q      <= '0;
            sb_q        <= '0;
            issue_q     <= '0;
            cfg_issue_q <= 1'b0;
            iss_vd_q    <= '0;
            iss_vs1_q   <= '0;
            iss_vs2_q   <= '0;
            iss_vs3_q   <= '0;
            cap_vd_q    <= '0;
            cap_vs1_q   <= '0;
            cap_vs2_q   <= '0;
            cap_vs3_q   <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                owner_vd_q[u] <= '0;
            end
        end else begin
            unit_busy_q <= unit_busy_d;
            owns_q      <= owns_d;
            sb_q        <= sb_d;
            issue_q     <= issue_d;
            cfg_issue_q <= cfg_issue_d;
            iss_vd_q    <= iss_vd_d;
            iss_vs1_q   <= iss_vs1_d;
            iss_vs2_q   <= iss_vs2_d;
            iss_vs3_q   <= iss_vs3_d;
            cap_vd_q    <= cap_vd_d;
            cap_vs1_q   <= cap_vs1_d;
            cap_vs2_q   <= cap_vs2_d;
            cap_vs3_q   <= cap_vs3_d;
            owner_vd_q  <= owner_vd_d;
        end
    end

    assign issue      = issue_q;
    assign cfg_issue  = cfg_issue_q;
    assign iss_vd     = iss_vd_q;
    assign iss_vs1    = iss_vs1_q;
    assign iss_vs2    = iss_vs2_q;
    assign iss_vs3    = iss_vs3_q;
    assign unit_busy  = unit_busy_q;
    assign sb_pending = sb_q;
    assign idle       = (state_q == ST_RUN) && (unit_busy_q == '0) && (sb_q == '0);

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed bench for v_issue_ctrl: a cycle-by-cycle vector table for the
// issue/hazard paths, plus hand-written vconfig drain and async-reset sequences.
module tb_v_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_vconfig;
    logic [2:0]  in_unit;
    logic [4:0]  in_vd, in_vs1, in_vs2, in_vs3;
    logic        in_rd_vs1, in_rd_vs2, in_rd_vs3, in_wr_vd;
    logic [4:0]  unit_done, issue, unit_busy;
    logic        cfg_issue, idle;
    logic [4:0]  iss_vd, iss_vs1, iss_vs2, iss_vs3;
    logic [31:0] sb_pending;

    int n_pass  = 0;
    int n_total = 0;

    v_issue_ctrl #(.NUM_VREG(32), .NUM_UNITS(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
        .in_is_vconfig(in_is_vconfig), .in_vd(in_vd), .in_vs1(in_vs1),
        .in_vs2(in_vs2), .in_vs3(in_vs3), .in_rd_vs1(in_rd_vs1),
        .in_rd_vs2(in_rd_vs2), .in_rd_vs3(in_rd_vs3), .in_wr_vd(in_wr_vd),
        .unit_done(unit_done), .issue(issue), .cfg_issue(cfg_issue),
        .iss_vd(iss_vd), .iss_vs1(iss_vs1), .iss_vs2(iss_vs2), .iss_vs3(iss_vs3),
        .unit_busy(unit_busy), .sb_pending(sb_pending), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  unit;
        logic [4:0]  vd, vs1, vs2, vs3;
        logic        rd1, rd2, rd3, wr;
        logic [4:0]  done;
        logic        exp_ready;
        logic [4:0]  exp_issue;
        logic [4:0]  exp_busy;
        logic [31:0] exp_sb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [2:0] u, logic [4:0] vd, logic [4:0] s1,
                                logic [4:0] s2, logic [4:0] s3, logic r1, logic r2,
                                logic r3, logic w, logic [4:0] dn, logic er,
                                logic [4:0] ei, logic [4:0] eb, logic [31:0] es);
        vec_t t;
        t.valid = v; t.unit = u; t.vd = vd; t.vs1 = s1; t.vs2 = s2; t.vs3 = s3;
        t.rd1 = r1; t.rd2 = r2; t.rd3 = r3; t.wr = w; t.done = dn;
        t.exp_ready = er; t.exp_issue = ei; t.exp_busy = eb; t.exp_sb = es;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(logic v, logic cfg, logic [2:0] u, logic [4:0] vd, logic [4:0] s1,
                         logic [4:0] s2, logic [4:0] s3, logic r1, logic r2, logic r3,
                         logic w, logic [4:0] dn);
        in_valid = v; in_is_vconfig = cfg; in_unit = u; in_vd = vd;
        in_vs1 = s1; in_vs2 = s2; in_vs3 = s3;
        in_rd_vs1 = r1; in_rd_vs2 = r2; in_rd_vs3 = r3; in_wr_vd = w;
        unit_done = dn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Cycle trace: valid unit vd vs1 vs2 vs3 rd1 rd2 rd3 wr done | ready issue busy sb
        vecs.push_back(mk(1, 1, 3, 1, 2, 0, 1, 1, 0, 1, 5'b00000, 1, 5'b00001, 5'b00001, 32'h8));
        vecs.push_back(mk(1, 2, 4, 0, 3, 0, 0, 1, 0, 1, 5'b00000, 0, 5'b00000, 5'b00001, 32'h8));
        vecs.push_back(mk(1, 2, 4, 0, 3, 0, 0, 1, 0, 1, 5'b00001, 1, 5'b00010, 5'b00010, 32'h10));
        vecs.push_back(mk(1, 1, 8, 9, 0, 0, 1, 0, 0, 1, 5'b00000, 1, 5'b00001, 5'b00011, 32'h110));
        vecs.push_back(mk(1, 3, 10, 0, 11, 0, 0, 1, 0, 1, 5'b00000, 1, 5'b00100, 5'b00111, 32'h510));
        vecs.push_back(mk(1, 5, 12, 0, 0, 5, 0, 0, 1, 0, 5'b00000, 1, 5'b10000, 5'b10111, 32'h510));
        vecs.push_back(mk(1, 1, 13, 14, 0, 0, 1, 0, 0, 1, 5'b00000, 0, 5'b00000, 5'b10111, 32'h510));
        vecs.push_back(mk(1, 0, 4, 4, 0, 0, 1, 0, 0, 1, 5'b00000, 1, 5'b00000, 5'b10111, 32'h510));
        vecs.push_back(mk(1, 7, 4, 4, 0, 0, 1, 0, 0, 1, 5'b00000, 1, 5'b00000, 5'b10111, 32'h510));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 1, 5'b00000, 5'b00000, 32'h0));
        vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 1, 5'b00001, 5'b00001, 32'h80));
        vecs.push_back(mk(1, 5, 7, 20, 0, 0, 1, 0, 0, 1, 5'b00001, 1, 5'b10000, 5'b10000, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 5'b00000, 5'b10000, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000, 1, 5'b00000, 5'b00000, 32'h0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 1, 5'b00001, 5'b00001, 32'h2));
        vecs.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 0, 5'b00000, 5'b00001, 32'h2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 5'b00000, 5'b00000, 32'h0));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_issue", 32'(issue), 32'h0);
        chk("reset_busy", 32'(unit_busy), 32'h0);
        chk("reset_sb", sb_pending, 32'h0);
        chk("reset_cfg_issue", 32'(cfg_issue), 32'h0);
        chk("reset_idle", 32'(idle), 32'h1);
        rst = 1'b0;
        tick();

        // Table-driven cycle trace
        foreach (vecs[i]) begin
            drive(vecs[i].valid, 0, vecs[i].unit, vecs[i].vd, vecs[i].vs1, vecs[i].vs2,
                  vecs[i].vs3, vecs[i].rd1, vecs[i].rd2, vecs[i].rd3, vecs[i].wr, vecs[i].done);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            tick();
            $display("vec %0d: unit=%0d vd=%0d done=%b ready=%0b issue=%b busy=%b sb=%h",
                     i, vecs[i].unit, vecs[i].vd, vecs[i].done, vecs[i].exp_ready,
                     issue, unit_busy, sb_pending);
            chk($sformatf("v%0d_issue", i), 32'(issue), 32'(vecs[i].exp_issue));
            chk($sformatf("v%0d_busy", i), 32'(unit_busy), 32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_sb", i), sb_pending, vecs[i].exp_sb);
            if (vecs[i].exp_issue != 5'b0)
                chk($sformatf("v%0d_iss_vd", i), 32'(iss_vd), 32'(vecs[i].vd));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0);
        #1;
        chk("trace_end_idle", 32'(idle), 32'h1);

        // vconfig behind a busy sldu
        drive(1, 0, 4, 15, 0, 16, 0, 0, 1, 0, 1, 5'b0);
        tick();
        chk("cfg_sldu_issue", 32'(issue), 32'h08);
        drive(1, 1, 1, 2, 17, 18, 19, 0, 0, 0, 0, 5'b0);
        #1;
        chk("cfg_present_ready", 32'(in_ready), 32'h0);
        tick();
        $display("vconfig captured: vd=2 vs1=17 vs2=18 vs3=19");
        drive(1, 0, 1, 21, 0, 0, 0, 0, 0, 0, 1, 5'b0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("drain%0d_ready", k), 32'(in_ready), 32'h0);
            tick();
            chk($sformatf("drain%0d_cfg_issue", k), 32'(cfg_issue), 32'h0);
            chk($sformatf("drain%0d_issue", k), 32'(issue), 32'h0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01000);
        tick();
        unit_done = 5'b0;
        for (int k = 0; k < 8 && cfg_issue !== 1'b1; k++) tick();
        $display("vconfig issue: cfg_issue=%0b vd=%0d vs1=%0d vs2=%0d vs3=%0d",
                 cfg_issue, iss_vd, iss_vs1, iss_vs2, iss_vs3);
        chk("cfg_issue_seen", 32'(cfg_issue), 32'h1);
        chk("cfg_iss_vd", 32'(iss_vd), 32'd2);
        chk("cfg_iss_vs1", 32'(iss_vs1), 32'd17);
        chk("cfg_iss_vs2", 32'(iss_vs2), 32'd18);
        chk("cfg_iss_vs3", 32'(iss_vs3), 32'd19);
        chk("cfg_unit_issue", 32'(issue), 32'h0);
        chk("cfg_state_ready", 32'(in_ready), 32'h0);
        chk("cfg_state_idle", 32'(idle), 32'h0);
        tick();
        chk("cfg_pulse_end", 32'(cfg_issue), 32'h0);
        chk("cfg_back_idle", 32'(idle), 32'h1);
        chk("cfg_back_ready", 32'(in_ready), 32'h1);

        // Async reset in the middle of a drain
        drive(1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1, 5'b0);
        tick();
        drive(1, 0, 2, 6, 0, 0, 0, 0, 0, 0, 1, 5'b0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0);
        chk("prerst_busy", 32'(unit_busy), 32'h03);
        chk("prerst_sb", sb_pending, 32'h60);
        chk("prerst_ready", 32'(in_ready), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        $display("async reset: busy=%b sb=%h iss_vd=%0d idle=%0b", unit_busy, sb_pending, iss_vd, idle);
        chk("rst_busy", 32'(unit_busy), 32'h0);
        chk("rst_sb", sb_pending, 32'h0);
        chk("rst_iss_vd", 32'(iss_vd), 32'h0);
        chk("rst_issue", 32'(issue), 32'h0);
        chk("rst_cfg_issue", 32'(cfg_issue), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        #1;
        rst = 1'b0;
        tick();
        unit_done = 5'b00011;
        tick();
        unit_done = 5'b0;
        chk("stale_busy", 32'(unit_busy), 32'h0);
        chk("stale_sb", sb_pending, 32'h0);
        chk("stale_idle", 32'(idle), 32'h1);
        drive(1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 1, 5'b0);
        #1;
        chk("postrst_ready", 32'(in_ready), 32'h1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0);
        $display("post-reset alu issue: issue=%b iss_vd=%0d", issue, iss_vd);
        chk("postrst_issue", 32'(issue), 32'h01);
        chk("postrst_iss_vd", 32'(iss_vd), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
